// File: rtl/cva6_pkg.sv
// rtl/cva6_pkg.sv - shared cva6 types and width helpers for the push arbiter
package cva6_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ACK   = 2'd3
    } push_arb_state_e;

    localparam int unsigned DEFAULT_NR_PORTS = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned GNT_ID_W = idx_w(DEFAULT_NR_PORTS);

endpackage

// File: rtl/cva6_rr_arb.sv
// rtl/cva6_rr_arb.sv - round-robin pick of the first requester at or above rr_ptr
module cva6_rr_arb
    import cva6_pkg::*;
#(
    parameter int unsigned NR_PORTS = DEFAULT_NR_PORTS,
    parameter int unsigned IDX_W    = idx_w(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    rr_ptr_i,
    input  logic                enable_i,
    output logic [NR_PORTS-1:0] gnt_onehot_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_onehot_o = '0;
        idx_o        = '0;
        valid_o      = 1'b0;
        sum          = '0;
        cand         = '0;
        // rr_ptr < NR_PORTS, so a single subtraction wraps the offset
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NR_PORTS)) begin
                sum = sum - (IDX_W+1)'(NR_PORTS);
            end
            cand = sum[IDX_W-1:0];
            if (enable_i && !valid_o && req_i[cand]) begin
                valid_o            = 1'b1;
                idx_o              = cand;
                gnt_onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cva6_fifo_push_arb.sv
// rtl/cva6_fifo_push_arb.sv - shares one FIFO push port among NR_PORTS requesters with flush/drain control
module cva6_fifo_push_arb
    import cva6_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned IDX_W      = idx_w(NR_PORTS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_PORTS-1:0]            req_valid_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] req_data_i,
    output logic [NR_PORTS-1:0]            req_ready_o,
    input  logic                           fifo_full_i,
    input  logic                           fifo_empty_i,
    output logic                           fifo_push_o,
    output logic [DATA_WIDTH-1:0]          fifo_data_o,
    output logic                           fifo_flush_o,
    output logic [IDX_W-1:0]               gnt_id_o,
    input  logic                           flush_req_i,
    input  logic                           drain_req_i,
    output logic                           ack_o
);

    if (NR_PORTS < 2 || NR_PORTS > 16 || DEPTH < 1 || ADDR_DEPTH < 1) begin : g_param_check
        $error("cva6_fifo_push_arb: parameter out of range");
    end

    push_arb_state_e      state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic                 flush_q;
    logic                 ack_q;

    logic                 arb_en;
    logic                 arb_valid;
    logic [IDX_W-1:0]     arb_idx;
    logic [NR_PORTS-1:0]  arb_gnt;

    assign arb_en = (state_q == ST_RUN) && !fifo_full_i;

    cva6_rr_arb #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_rr_arb (
        .req_i        (req_valid_i),
        .rr_ptr_i     (rr_ptr_q),
        .enable_i     (arb_en),
        .gnt_onehot_o (arb_gnt),
        .idx_o        (arb_idx),
        .valid_o      (arb_valid)
    );

    assign req_ready_o  = arb_gnt;
    assign fifo_push_o  = arb_valid;
    assign gnt_id_o     = arb_valid ? arb_idx : '0;
    assign fifo_flush_o = flush_q;
    assign ack_o        = ack_q;
    assign rr_ptr_d     = (arb_idx == IDX_W'(NR_PORTS - 1)) ? '0 : arb_idx + 1'b1;

    always_comb begin
        fifo_data_o = '0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            if (arb_valid && arb_idx == IDX_W'(k)) begin
                fifo_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // flush/ack strobes are registered alongside the state they belong to
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            rr_ptr_q <= '0;
            flush_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            ack_q   <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (arb_valid) begin
                        rr_ptr_q <= rr_ptr_d;
                    end
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end else if (drain_req_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end else if (fifo_empty_i) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    rr_ptr_q <= '0;
                    state_q  <= ST_ACK;
                    ack_q    <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_fifo_push_arb.sv
// tb/tb_cva6_fifo_push_arb.sv - directed self-checking bench for cva6_fifo_push_arb
module tb_cva6_fifo_push_arb;
    import cva6_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  valid;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]  ready;
    logic           full;
    logic           empty;
    logic           push;
    logic [DW-1:0]  fdata;
    logic           flush;
    logic [1:0]     gnt;
    logic           flush_req;
    logic           drain_req;
    logic           ack;

    int n_vec = 0;
    int n_err = 0;

    cva6_fifo_push_arb #(.NR_PORTS(NR), .DATA_WIDTH(DW), .DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (valid),
        .req_data_i   (data),
        .req_ready_o  (ready),
        .fifo_full_i  (full),
        .fifo_empty_i (empty),
        .fifo_push_o  (push),
        .fifo_data_o  (fdata),
        .fifo_flush_o (flush),
        .gnt_id_o     (gnt),
        .flush_req_i  (flush_req),
        .drain_req_i  (drain_req),
        .ack_o        (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input int port);
        chk({tag, "_ready"}, 64'(ready), 64'(4'b0001 << port));
        chk({tag, "_push"}, 64'(push), 64'd1);
        chk({tag, "_gnt"}, 64'(gnt), 64'(port));
        chk({tag, "_data"}, 64'(fdata), 64'(32'hA0 + port));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 64'(ready), 64'd0);
        chk({tag, "_push"}, 64'(push), 64'd0);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_data"}, 64'(fdata), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid = '0; full = 1'b0; empty = 1'b1;
        flush_req = 1'b0; drain_req = 1'b0;
        for (int k = 0; k < NR; k++) data[k*DW +: DW] = 32'hA0 + k;
        cyc(); cyc();
        chk_idle("reset");
        chk("reset_flush", 64'(flush), 64'd0);
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_rr", 64'(dut.rr_ptr_q), 64'd0);
        chk("reset_state", 64'(dut.state_q), 64'(ST_RUN));
        rst_n = 1'b1;
        cyc();

        // all four requesting: strict rotation 0,1,2,3,0,1,2,3
        valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 chk_grant($sformatf("rot%0d", i), i % 4);
            cyc();
        end

        // move rr_ptr to 2, then wrap from 2 to port 0
        valid = 4'b0010;
        #1 chk_grant("pre_wrap", 1);
        cyc();
        chk("rr_is2", 64'(dut.rr_ptr_q), 64'd2);
        valid = 4'b0011;
        #1 chk_grant("wrap", 0);
        cyc();
        chk("wrap_rr", 64'(dut.rr_ptr_q), 64'd1);

        // full blocks everything, rr_ptr holds
        full = 1'b1; valid = 4'b1111;
        #1 chk_idle("full");
        cyc();
        chk("full_rr", 64'(dut.rr_ptr_q), 64'd1);
        full = 1'b0; valid = 4'b1000;
        #1 chk_grant("search_up", 3);
        cyc();
        valid = 4'b0000;
        #1 chk_idle("novalid");
        chk("rr_wrapped0", 64'(dut.rr_ptr_q), 64'd0);

        // flush pulse with a grant in the same cycle
        valid = 4'b0110; flush_req = 1'b1;
        #1 chk_grant("flush_t", 1);
        cyc();
        flush_req = 1'b0;
        #1 chk_idle("flush_t1");
        chk("flush_t1_flush", 64'(flush), 64'd1);
        chk("flush_t1_ack", 64'(ack), 64'd0);
        cyc();
        #1 chk_idle("flush_t2");
        chk("flush_t2_flush", 64'(flush), 64'd0);
        chk("flush_t2_ack", 64'(ack), 64'd1);
        cyc();
        chk("flush_rr0", 64'(dut.rr_ptr_q), 64'd0);
        #1 chk_grant("after_flush", 1);
        chk("after_flush_ack", 64'(ack), 64'd0);
        cyc();

        // drain with three entries popped one per cycle
        valid = 4'b0000; drain_req = 1'b1; empty = 1'b0;
        #1 chk_idle("drain_t");
        cyc();
        drain_req = 1'b0; valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1 chk_idle($sformatf("drain_wait%0d", i));
            chk($sformatf("drain_wait%0d_ack", i), 64'(ack), 64'd0);
            cyc();
        end
        empty = 1'b1;
        #1 chk_idle("drain_empty");
        chk("drain_empty_ack", 64'(ack), 64'd0);
        cyc();
        #1 chk_idle("drain_ackcyc");
        chk("drain_ack", 64'(ack), 64'd1);
        chk("drain_noflush", 64'(flush), 64'd0);
        cyc();
        #1 chk_grant("after_drain", 2);
        chk("after_drain_ack", 64'(ack), 64'd0);
        cyc();

        // flush escalates an ongoing drain
        valid = 4'b0000; drain_req = 1'b1; empty = 1'b0;
        cyc();
        drain_req = 1'b0; flush_req = 1'b1; valid = 4'b1111;
        #1 chk_idle("esc_a1");
        chk("esc_a1_flush", 64'(flush), 64'd0);
        cyc();
        flush_req = 1'b0;
        #1 chk("esc_a2_flush", 64'(flush), 64'd1);
        chk("esc_a2_ack", 64'(ack), 64'd0);
        chk("esc_a2_push", 64'(push), 64'd0);
        cyc();
        #1 chk("esc_a3_ack", 64'(ack), 64'd1);
        chk("esc_a3_flush", 64'(flush), 64'd0);
        cyc();
        #1 chk("esc_a4_ack", 64'(ack), 64'd0);
        chk_grant("esc_a4", 0);
        cyc();

        // reset mid-drain aborts without ack
        valid = 4'b0000; drain_req = 1'b1; empty = 1'b0;
        cyc();
        drain_req = 1'b0;
        #1 chk("rst_pre_state", 64'(dut.state_q), 64'(ST_DRAIN));
        #2 rst_n = 1'b0;
        #1 chk("rst_async_state", 64'(dut.state_q), 64'(ST_RUN));
        chk("rst_async_ack", 64'(ack), 64'd0);
        empty = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rst_post%0d_ack", i), 64'(ack), 64'd0);
            chk($sformatf("rst_post%0d_state", i), 64'(dut.state_q), 64'(ST_RUN));
        end
        chk("rst_post_rr", 64'(dut.rr_ptr_q), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
